// File: rtl/sdr_cmd_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sdr_cmd_monitor
// Purpose  : Passive SDRAM command-bus monitor. Decodes cs/ras/cas/we/ba/addr
//            every clock and tracks per-bank open state and ACT/PRE timing.
//            Flags protocol/timing violations and keeps saturating counters.
//            The monitor never drives the SDRAM bus.
// Options  : define SDR_MON_AUTOPRE_EN to treat RD/WR with addr[10]=1 as
//            auto-precharge (bank closes, t_pre restarts on that cycle).
// Revision : 1.0  initial release
// ============================================================================
module sdr_cmd_monitor #(
    parameter int SDR_AW = 13,
    parameter int TRCD   = 3,
    parameter int TRP    = 3,
    parameter int TRAS   = 6,
    parameter int CNT_W  = 16
) (
    input  logic              sdram_clk,
    input  logic              sdram_resetn,
    input  logic              sdr_init_done,
    input  logic              sdr_cs_n,
    input  logic              sdr_ras_n,
    input  logic              sdr_cas_n,
    input  logic              sdr_we_n,
    input  logic [1:0]        sdr_ba,
    input  logic [SDR_AW-1:0] sdr_addr,
    input  logic              clr_i,
    output logic [CNT_W-1:0]  act_cnt,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  ref_cnt,
    output logic [3:0]        bank_open,
    output logic              err_o,
    output logic [2:0]        err_code,
    output logic              err_sticky
);

    // {ras_n, cas_n, we_n} encodings
    localparam logic [2:0] c_CMD_ACT = 3'b011;
    localparam logic [2:0] c_CMD_RD  = 3'b101;
    localparam logic [2:0] c_CMD_WR  = 3'b100;
    localparam logic [2:0] c_CMD_PRE = 3'b010;
    localparam logic [2:0] c_CMD_REF = 3'b001;
    localparam logic [2:0] c_CMD_MRS = 3'b000;

    // Thresholds widened to 5 bits so timer+1 never overflows in compares
    localparam logic [4:0] c_TRCD = 5'(TRCD);
    localparam logic [4:0] c_TRP  = 5'(TRP);
    localparam logic [4:0] c_TRAS = 5'(TRAS);

    logic [3:0]       r_bank_open;
    logic [3:0]       r_t_act [4];
    logic [3:0]       r_t_pre [4];
    logic             r_err_o;
    logic [2:0]       r_err_code;
    logic             r_err_sticky;
    logic [CNT_W-1:0] r_act_cnt;
    logic [CNT_W-1:0] r_rd_cnt;
    logic [CNT_W-1:0] r_wr_cnt;
    logic [CNT_W-1:0] r_ref_cnt;

    logic [2:0] w_cmd;
    logic       w_act, w_rd, w_wr, w_rw, w_pre, w_ref, w_mrs;
    logic       w_a10, w_sel_open, w_any_open, w_autopre;
    logic [3:0] w_trcd_short, w_tras_short, w_trp_short;
    logic [3:0] w_pre_hit, w_act_hit, w_close;
    logic [2:0] w_err_code;
    logic       w_err;
    logic       w_addr_unused;

    // Only addr[10] carries meaning for the monitor
    assign w_addr_unused = ^sdr_addr;

    assign w_cmd      = {sdr_ras_n, sdr_cas_n, sdr_we_n};
    assign w_act      = !sdr_cs_n && (w_cmd == c_CMD_ACT);
    assign w_rd       = !sdr_cs_n && (w_cmd == c_CMD_RD);
    assign w_wr       = !sdr_cs_n && (w_cmd == c_CMD_WR);
    assign w_pre      = !sdr_cs_n && (w_cmd == c_CMD_PRE);
    assign w_ref      = !sdr_cs_n && (w_cmd == c_CMD_REF);
    assign w_mrs      = !sdr_cs_n && (w_cmd == c_CMD_MRS);
    assign w_rw       = w_rd || w_wr;
    assign w_a10      = sdr_addr[10];
    assign w_sel_open = r_bank_open[sdr_ba];
    assign w_any_open = |r_bank_open;

`ifdef SDR_MON_AUTOPRE_EN
    assign w_autopre = w_rw && w_a10;
`else
    assign w_autopre = 1'b0;
`endif

    // Per-bank timing windows and which banks this command opens or closes
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_trcd_short[i] = (({1'b0, r_t_act[i]} + 5'd1) < c_TRCD);
            w_tras_short[i] = r_bank_open[i] && (({1'b0, r_t_act[i]} + 5'd1) < c_TRAS);
            w_trp_short[i]  = (({1'b0, r_t_pre[i]} + 5'd1) < c_TRP);
            w_pre_hit[i]    = w_pre && (w_a10 || (sdr_ba == 2'(i)));
            w_act_hit[i]    = w_act && (sdr_ba == 2'(i));
            w_close[i]      = r_bank_open[i] &&
                              (w_pre_hit[i] || (w_autopre && (sdr_ba == 2'(i))));
        end
    end

    // Violation priority: the lowest applicable code wins
    always_comb begin
        w_err_code = 3'd0;
        if (w_act && w_sel_open)                          w_err_code = 3'd1;
        else if (w_rw && !w_sel_open)                     w_err_code = 3'd2;
        else if (w_rw && w_trcd_short[sdr_ba])            w_err_code = 3'd3;
        else if (w_pre && |(w_tras_short & w_pre_hit))    w_err_code = 3'd4;
        else if (w_act && w_trp_short[sdr_ba])            w_err_code = 3'd5;
        else if ((w_ref || w_mrs) && w_any_open)          w_err_code = 3'd6;
        else if ((w_act || w_rw) && !sdr_init_done)       w_err_code = 3'd7;
    end

    assign w_err = |w_err_code;

    // Bank open state and saturating ACT / IDLE age timers
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            r_bank_open <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_t_act[i] <= 4'hF;
                r_t_pre[i] <= 4'hF;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_act_hit[i])
                    r_bank_open[i] <= 1'b1;
                else if (w_close[i])
                    r_bank_open[i] <= 1'b0;

                if (w_act_hit[i])
                    r_t_act[i] <= 4'h0;
                else if (r_t_act[i] != 4'hF)
                    r_t_act[i] <= r_t_act[i] + 4'h1;

                if (w_close[i])
                    r_t_pre[i] <= 4'h0;
                else if (r_t_pre[i] != 4'hF)
                    r_t_pre[i] <= r_t_pre[i] + 4'h1;
            end
        end
    end

    // Registered error pulse; code persists until the next violation
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            r_err_o    <= 1'b0;
            r_err_code <= 3'd0;
        end else begin
            r_err_o <= w_err;
            if (w_err)
                r_err_code <= w_err_code;
        end
    end

    // Sticky error and saturating command counters; clear takes priority
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            r_err_sticky <= 1'b0;
            r_act_cnt    <= '0;
            r_rd_cnt     <= '0;
            r_wr_cnt     <= '0;
            r_ref_cnt    <= '0;
        end else if (clr_i) begin
            r_err_sticky <= 1'b0;
            r_act_cnt    <= '0;
            r_rd_cnt     <= '0;
            r_wr_cnt     <= '0;
            r_ref_cnt    <= '0;
        end else begin
            if (w_err)
                r_err_sticky <= 1'b1;
            if (w_act && !(&r_act_cnt))
                r_act_cnt <= r_act_cnt + 1'b1;
            if (w_rd && !(&r_rd_cnt))
                r_rd_cnt <= r_rd_cnt + 1'b1;
            if (w_wr && !(&r_wr_cnt))
                r_wr_cnt <= r_wr_cnt + 1'b1;
            if (w_ref && !(&r_ref_cnt))
                r_ref_cnt <= r_ref_cnt + 1'b1;
        end
    end

    assign act_cnt    = r_act_cnt;
    assign rd_cnt     = r_rd_cnt;
    assign wr_cnt     = r_wr_cnt;
    assign ref_cnt    = r_ref_cnt;
    assign bank_open  = r_bank_open;
    assign err_o      = r_err_o;
    assign err_code   = r_err_code;
    assign err_sticky = r_err_sticky;

endmodule
`default_nettype wire

// File: doc/sdr_cmd_monitor.md
Name: sdr_cmd_monitor

Overview:
Passive SDRAM command-bus monitor downstream of the SDRAM controller pads. It decodes the registered cs/ras/cas/we/ba/addr command stream every sdram_clk cycle and tracks open/closed state and timing per bank. It flags protocol and timing violations and keeps saturating command counters for the test environment's assertion and coverage layer. It never drives the SDRAM bus.

Parameters:
SDR_AW, 13, SDRAM address width
TRCD, 3, minimum cycles ACT -> RD/WR, same bank (1..15)
TRP, 3, minimum cycles PRE -> ACT, same bank (1..15)
TRAS, 6, minimum cycles ACT -> PRE, same bank (1..15)
CNT_W, 16, width of each command counter

Ports:
sdram_clk  in  1  monitor clock, SDRAM clock domain
sdram_resetn  in  1  asynchronous active-low reset
sdr_init_done  in  1  controller init sequence complete
sdr_cs_n  in  1  chip select, active low
sdr_ras_n  in  1  row strobe
sdr_cas_n  in  1  column strobe
sdr_we_n  in  1  write enable
sdr_ba  in  2  bank address
sdr_addr  in  SDR_AW  address; bit 10 = all-banks / auto-precharge
clr_i  in  1  synchronous clear of counters and sticky error
act_cnt  out  CNT_W  ACT count
rd_cnt  out  CNT_W  READ count
wr_cnt  out  CNT_W  WRITE count
ref_cnt  out  CNT_W  REFRESH count
bank_open  out  4  per-bank ACTIVE flag
err_o  out  1  one-cycle violation pulse
err_code  out  3  code of most recent violation
err_sticky  out  1  set on any violation until clr_i

Behaviour:
- Decode, combinational on inputs:
  - cs_n=1 -> NOP.
  - {ras_n,cas_n,we_n}: 111 NOP, 011 ACT, 101 RD, 100 WR, 010 PRE, 001 REF, 000 MRS, 110 BST.
- Per-bank state: IDLE / ACTIVE.
  - ACT: IDLE -> ACTIVE.
  - PRE: ACTIVE -> IDLE for bank sdr_ba; if addr[10]=1, all banks go IDLE.
  - PRE to an IDLE bank is legal and has no effect.
- Per-bank 4-bit saturating timers:
  - t_act: cycles since last ACT.
  - t_pre: cycles since the bank went IDLE.
  - The event cycle loads 0; each following cycle increments; timers hold at 15.
  - On reset both timers are 15, so the first ACT is legal.
- Violation codes (checked on the command cycle):
  - 1: ACT to an ACTIVE bank.
  - 2: RD/WR to an IDLE bank.
  - 3: RD/WR with t_act+1 < TRCD.
  - 4: PRE to an ACTIVE bank with t_act+1 < TRAS (all-banks PRE checks every ACTIVE bank).
  - 5: ACT with t_pre+1 < TRP.
  - 6: REF while any bank is ACTIVE.
  - 7: ACT/RD/WR while sdr_init_done=0.
- If several codes apply, the lowest code is reported. State updates happen regardless of violations.
- Error outputs:
  - err_o and err_code are registered; latency is 1 cycle after the command.
  - err_code holds its value until the next violation.
  - err_sticky sets with err_o.
- Counters:
  - Increment 1 cycle after the matching command.
  - Saturate at all-ones; no wrap.
- clr_i:
  - Zeroes counters and err_sticky on the next edge. If it coincides with a command, the clear wins and that command is not counted.
  - Bank state, timers, err_code and err_o are unaffected.
- Reset (async, sdramresetn low):
  - Counters 0, bank_open 0, err_o 0, err_code 0, err_sticky 0, timers 15.
  - Reset mid-burst discards all bank state.
- BST, MRS and NOP only age timers. MRS while any bank is ACTIVE raises code 6.

Optional Feature:
SDR_MON_AUTOPRE_EN
- Defined: RD/WR with addr[10]=1 is treated as auto-precharge. After the access is checked, the bank goes IDLE and t_pre loads 0 in that same cycle, so a following ACT is subject to TRP.
- Undefined: addr[10] on RD/WR is ignored and the bank stays ACTIVE.

Test Plan:
1. Reset, init_done=1, ACT b0 @0, RD b0 @3, PRE b0 @6 -> err_sticky=0, act_cnt=1, rd_cnt=1, bank_open=0000.
2. ACT b1 @0, WR b1 @1 (TRCD=3) -> err_o high cycle 2, err_code=3, wr_cnt=1, bank_open=0010.
3. ACT b2, ACT b2 again 4 cycles later -> err_code=1. Then PRE all, REF -> no new error, ref_cnt=1, bank_open=0000.
4. ACT b0, ACT b3, REF after 8 cycles -> err_code=6. Pulse clr_i -> counters 0, err_sticky 0, err_code still 6.
5. init_done=0, ACT b0 -> err_code=7. ACT b0 PRE b0 ACT b0 spaced 6,1 cycles -> err_code=5.
6. With SDR_MON_AUTOPRE_EN: ACT b0, RD b0 A10=1 @3, ACT b0 @4 -> err_code=5, bank_open[0]=1. Without the macro the same sequence gives err_code=1.
